// File: rtl/mod_reduce_seq_ctrl.sv
// mod_reduce_seq_ctrl: sequencer for a repeated-subtraction modular reduction datapath
//   clk, rst_n (sync, active low)
//   start, count_len[9:0], q[12:0]  : batch request, length and modulus
//   in_valid/in_ready               : coefficient load handshake
//   Nmod[12:0]                      : datapath register fed back for compare
//   R2, R3                          : datapath load/subtract/hold controls
//   out_valid/out_ready             : result handshake (result is Nmod)
//   coef_idx[9:0], busy, done, err  : batch status
module mod_reduce_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  count_len,
  input  logic [12:0] q,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] Nmod,
  output logic        R2,
  output logic        R3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  coef_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, LOAD, REDUCE, OUT, FIN} state_t;
  state_t state, state_nx;
  logic [9:0] len_r;
  logic ge, last;
  assign ge = Nmod >= q;
  assign last = coef_idx == len_r - 10'd1;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (q == '0 || count_len == '0) ? FIN : LOAD;
      LOAD:    if (in_valid) state_nx = REDUCE;
      REDUCE:  if (!ge) state_nx = OUT;
      OUT:     if (out_ready) state_nx = last ? FIN : LOAD;
      default: state_nx = IDLE;
    endcase
  end
  // R2=0 only on the load handshake, R3=0 only while a subtract is due
  always_comb begin
    in_ready  = state == LOAD;
    out_valid = state == OUT;
    R2        = !(state == LOAD && in_valid);
    R3        = !(state == REDUCE && ge);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      coef_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      len_r    <= '0;
    end else begin
      done <= state_nx == FIN;
      if (state == IDLE && start) begin
        err      <= q == '0;
        len_r    <= count_len;
        coef_idx <= '0;
        busy     <= q != '0 && count_len != '0;
      end else if (state == OUT && out_ready && !last) coef_idx <= coef_idx + 10'd1;
      if (state == FIN) busy <= 1'b0;
    end
endmodule

// File: tb/tb_mod_reduce_seq_ctrl.sv
// tb_mod_reduce_seq_ctrl: scoreboard bench with a datapath model and coefficient source
module tb_mod_reduce_seq_ctrl;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [9:0] count_len = 0;
  logic [12:0] q = 0, Nmod = 0, n_val = 0;
  logic in_ready, R2, R3, out_valid, busy, done, err;
  logic [9:0] coef_idx;
  typedef struct {int res; int idx; int lat;} exp_t;
  exp_t sb[$];
  logic [12:0] src_q[$];
  int tests = 0, fails = 0, cyc = 0, hs_cyc = 0, done_cnt = 0, irdy_cnt = 0;
  bit hs_pend = 0, seen = 0;

  mod_reduce_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count_len(count_len), .q(q),
    .in_valid(in_valid), .in_ready(in_ready), .Nmod(Nmod), .R2(R2), .R3(R3),
    .out_valid(out_valid), .out_ready(out_ready), .coef_idx(coef_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk)
    if (!R2) Nmod <= n_val;
    else if (!R3) Nmod <= Nmod - q;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [12:0] dummy;
    if (hs_pend && src_q.size() > 0) dummy = src_q.pop_front();
    in_valid = src_q.size() > 0;
    n_val = in_valid ? src_q[0] : 13'd0;
    hs_pend = in_valid && in_ready;
    if (hs_pend) hs_cyc = cyc;
    if (done) done_cnt++;
    if (in_ready) irdy_cnt++;
  end

  always @(negedge clk)
    if (rst_n && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        if (!seen) begin
          chk("latency", cyc - hs_cyc, sb[0].lat);
          seen = 1;
        end
        chk("result", Nmod, sb[0].res);
        chk("coef_idx", coef_idx, sb[0].idx);
        chk("out_hold_r2r3", {R2, R3}, 2'b11);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int len, input int qv);
    count_len = 10'(len);
    q = 13'(qv);
    start = 1;
    step;
    start = 0;
  endtask

  task automatic wait_out(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (out_valid) return;
      step;
    end
    chk("wait_out_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) return;
      step;
    end
    chk("wait_done_timeout", 0, 1);
  endtask

  task automatic push(input int n, input int res, input int idx, input int lat);
    src_q.push_back(13'(n));
    sb.push_back('{res, idx, lat});
  endtask

  initial begin
    int d0, i0;
    step;
    step;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_r2r3", {R2, R3}, 2'b11);
    chk("rst_coef_idx", coef_idx, 0);
    rst_n = 1;
    step;

    // N=10, q=3: three subtracts, result 1, out_valid 5 cycles after load, stall 5 cycles
    push(10, 1, 0, 5);
    d0 = done_cnt;
    go(1, 3);
    chk("busy_after_start", busy, 1);
    wait_out(20);
    repeat (5) step;
    chk("stall_out_valid", out_valid, 1);
    chk("stall_no_done", done_cnt - d0, 0);
    out_ready = 1;
    wait_done(5);
    chk("t1_done", done, 1);
    step;
    chk("t1_done_pulse", done, 0);
    chk("t1_busy_clear", busy, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // three coefficients with out_ready tied high, including N==q
    push(0, 0, 0, 2);
    push(4591, 0, 1, 3);
    push(8190, 3599, 2, 3);
    d0 = done_cnt;
    go(3, 4591);
    wait_done(60);
    step;
    chk("t2_one_done", done_cnt - d0, 1);
    chk("t2_sb_empty", sb.size(), 0);

    // q=0: straight to FIN with err, no load; err persists until next accepted start
    i0 = irdy_cnt;
    go(2, 0);
    chk("q0_done", done, 1);
    chk("q0_err", err, 1);
    chk("q0_busy", busy, 0);
    repeat (3) step;
    chk("q0_err_sticky", err, 1);
    chk("q0_no_in_ready", irdy_cnt - i0, 0);

    // count_len=0 clears err, pulses done, never loads; start during FIN ignored
    go(0, 5);
    chk("len0_err_cleared", err, 0);
    chk("len0_done", done, 1);
    count_len = 1;
    q = 3;
    start = 1;
    step;
    start = 0;
    chk("fin_start_ignored", in_ready, 0);
    chk("fin_start_busy", busy, 0);
    step;
    chk("len0_no_in_ready", irdy_cnt - i0, 0);

    // start while busy has no effect
    out_ready = 0;
    push(20, 6, 0, 4);
    push(5, 5, 1, 2);
    d0 = done_cnt;
    go(2, 7);
    wait_out(20);
    count_len = 5;
    start = 1;
    step;
    start = 0;
    chk("busy_start_idx", coef_idx, 0);
    chk("busy_start_busy", busy, 1);
    chk("busy_start_out_valid", out_valid, 1);
    out_ready = 1;
    wait_done(30);
    step;
    chk("t4_one_done", done_cnt - d0, 1);
    chk("t4_sb_empty", sb.size(), 0);

    // reset mid-REDUCE, then a fresh batch
    push(8000, 2, 0, 2668);
    go(1, 3);
    repeat (20) step;
    chk("mid_reduce_r3", R3, 0);
    rst_n = 0;
    sb.delete();
    src_q.delete();
    seen = 0;
    step;
    chk("mrst_busy", busy, 0);
    chk("mrst_r2r3", {R2, R3}, 2'b11);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_coef_idx", coef_idx, 0);
    rst_n = 1;
    step;
    push(100, 1, 0, 13);
    d0 = done_cnt;
    go(1, 9);
    wait_done(40);
    step;
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mod_reduce_seq_ctrl.md
MOD_REDUCE_SEQ_CTRL -- requirements
Module: mod_reduce_seq_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  in  1  Rising-edge clock shared with the reduction datapath.
REQ-004 rst_n  in  1  Synchronous active-low reset.
REQ-005 start  in  1  Single-cycle request to begin a batch; ignored while busy=1.
REQ-006 count_len  in  10  Number of coefficients in the batch (0..757); sampled when start is accepted.
REQ-007 q  in  13  Modulus; held stable by the user while busy=1; also drives the datapath.
REQ-008 in_valid / in_ready  in / out  1 / 1  Coefficient-input handshake; the datapath takes N directly from the source.
REQ-009 Nmod  in  13  Datapath register value fed back for comparison.
REQ-010 R2, R3  out  1, 1  Datapath controls: R2=0 loads N; R2=1,R3=0 makes Nmod<=Nmod-q; R2=1,R3=1 holds.
REQ-011 out_valid / out_ready  out / in  1 / 1  Result handshake; the result is Nmod.
REQ-012 coef_idx  out  10  Index of the coefficient currently in flight.
REQ-013 busy, done, err  out  1, 1, 1  Batch active; 1-cycle completion pulse; q==0 flag.

Function
REQ-014 States SHALL be IDLE, LOAD, REDUCE, OUT and FIN.
REQ-015 IDLE transitions:
- start=1, q!=0, count_len!=0 -> LOAD, latch count_len, set coef_idx=0, set busy=1.
- start=1 with count_len=0 -> FIN.
- start=1 with q=0 -> FIN and set err=1.
REQ-016 LOAD: in_ready=1. A handshake (in_valid=1) SHALL drive R2=0 in that same cycle, so the datapath captures N at that edge, and move to REDUCE.
REQ-017 REDUCE:
- Nmod>=q (unsigned): R2=1, R3=0; remain in REDUCE.
- Otherwise: R2=1, R3=1; move to OUT.
REQ-018 OUT: out_valid=1 and R2=R3=1. On out_ready=1:
- coef_idx = count_len-1 -> FIN.
- Otherwise coef_idx increments and the state moves to LOAD.
REQ-019 FIN: done=1 for exactly one cycle, busy=0 on the next cycle, then IDLE.
REQ-020 In every state and cycle not covered by REQ-016/017, R2=1 and R3=1 (hold).
REQ-021 R2, R3, in_ready and out_valid SHALL be combinational from the state, in_valid and the Nmod/q compare; all other outputs SHALL be registered.
REQ-022 Latency per coefficient = 1 (load) + floor(N/q) (subtracts) + 1 (compare) cycles to out_valid, with zero stall.
- N<q skips REDUCE subtractions.
- N=0 yields result 0.
REQ-023 Nmod=q exactly SHALL subtract once, giving 0.
REQ-024 out_valid SHALL hold, and Nmod SHALL stay unchanged, while out_ready=0.
REQ-025 start asserted while busy=1 SHALL have no effect; start coincident with a FIN cycle SHALL be ignored.
REQ-026 err SHALL stay set until the next accepted start, which clears it.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force, from any state including mid-REDUCE:
- state IDLE
- coef_idx=0, busy=0, done=0, err=0
- in_ready=0, out_valid=0, R2=1, R3=1
REQ-028 A reset abandons the in-flight coefficient; the datapath register value is don't-care after reset.

Verification
REQ-029 count_len=1, q=3, N=10 -> subtract 3 cycles, result 1, out_valid on cycle 5 after the load handshake, done pulse after out_ready.
REQ-030 count_len=3, q=4591, N={0, 4591, 8190}, out_ready tied 1 -> results {0, 0, 3599}, coef_idx 0,1,2, a single done pulse.
REQ-031 out_ready held 0 for 5 cycles in OUT -> out_valid stays 1, Nmod is stable, R2=R3=1 throughout.
REQ-032 start with q=0 -> FIN in one cycle, err=1, no in_ready; a later valid start clears err.
REQ-033 rst_n=0 mid-REDUCE (N=8000, q=3) -> next cycle state IDLE, busy=0, R3=1; a fresh batch then completes correctly.
REQ-034 count_len=0 -> done pulse with in_ready never asserted; start while busy -> ignored, coef_idx unaffected.
